// File: rtl/iq_pkg.sv
// iq_pkg: shared types and helpers for iq_word_unpacker
//   byteswap       - reverse the byte order of the low word_w bits of a word
//   extract_sample - optional byte swap, then take the top sample_w bits of the word
//   phase_t        - Q/I word phase of the unpacker FSM
//   pair_t         - buffered sample pair; fields sized for the widest legal build
//   params_ok      - elaboration-time legality check of the unpacker parameters
package iq_pkg;
    localparam int MAX_WORD_W = 64;
    localparam int MAX_SAMPLE_W = 32;
    localparam int MAX_CHAN_W = 8;
    typedef enum logic {Q_WAIT, I_WAIT} phase_t;
    typedef struct packed {
        logic [MAX_SAMPLE_W-1:0] i;
        logic [MAX_SAMPLE_W-1:0] q;
        logic [MAX_CHAN_W-1:0]   chan;
    } pair_t;
    function automatic logic [MAX_WORD_W-1:0] byteswap(input logic [MAX_WORD_W-1:0] w, input int word_w);
        logic [MAX_WORD_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_WORD_W / 8; b++)
            if (b < word_w / 8) r[8*b +: 8] = w[8*(word_w/8-1-b) +: 8];
        return r;
    endfunction
    // Upper bits of w beyond word_w must be zero so the shifted result is clean.
    function automatic logic [MAX_WORD_W-1:0] extract_sample(input logic [MAX_WORD_W-1:0] w, input int word_w,
                                                             input int sample_w, input bit swap);
        logic [MAX_WORD_W-1:0] s;
        s = swap ? byteswap(w, word_w) : w;
        return s >> (word_w - sample_w);
    endfunction
    function automatic bit params_ok(input int word_w, input int sample_w, input int channels,
                                     input int decim, input int gap, input int depth);
        return word_w % 8 == 0 && word_w >= 8 && word_w <= MAX_WORD_W &&
               sample_w >= 1 && sample_w <= word_w && sample_w <= MAX_SAMPLE_W &&
               channels >= 1 && channels <= (1 << MAX_CHAN_W) &&
               decim >= 1 && gap >= 1 && depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/iq_word_unpacker_sync_fifo.sv
// sync_fifo: single-clock FIFO carrying unpacked sample pairs
//   clk, rst_ni       - clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data    - push; ignored while full
//   rd_en, rd_data    - pop; rd_data shows the head entry combinationally
//   full, empty       - occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign rd_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk)
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/iq_word_unpacker.sv
// iq_word_unpacker: turns interleaved Q,I capture words into paced sample-pair strobes
//   clk, rst_ni            - clock, asynchronous active-low reset
//   clken_i                - clock enable; all state frozen when low
//   word_i, word_valid_i   - input word stream (Q then I, channel 0 upward)
//   word_ready_o           - equals clken_i; the source cannot stall
//   sync_i                 - realign: the next accepted word is Q of channel 0
//   err_clr_i              - clears overrun_o and drop_cnt_o
//   I_o, Q_o, chan_o       - last popped pair, held between strobes
//   dvalid_o               - one-cycle strobe per pair, at least GAP enabled cycles apart
//   overrun_o, drop_cnt_o  - sticky drop flag and saturating dropped-pair count
module iq_word_unpacker
    import iq_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int SAMPLE_W   = 10,
    parameter int CHANNELS   = 1,
    parameter int DECIM      = 1,
    parameter int GAP        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter bit BYTE_SWAP  = 1'b1,
    localparam int CHAN_W    = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                clken_i,
    input  logic [WORD_W-1:0]   word_i,
    input  logic                word_valid_i,
    output logic                word_ready_o,
    input  logic                sync_i,
    input  logic                err_clr_i,
    output logic [SAMPLE_W-1:0] I_o,
    output logic [SAMPLE_W-1:0] Q_o,
    output logic [CHAN_W-1:0]   chan_o,
    output logic                dvalid_o,
    output logic                overrun_o,
    output logic [7:0]          drop_cnt_o
);
    localparam int DEC_W = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int GAP_W = $clog2(GAP + 1);
    if (!params_ok(WORD_W, SAMPLE_W, CHANNELS, DECIM, GAP, FIFO_DEPTH)) begin : g_bad_params
        $error("iq_word_unpacker: illegal parameter set");
    end
    phase_t phase_q, phase_d, phase_cur;
    logic [CHAN_W-1:0] chan_q, chan_d, chan_cur;
    logic [DEC_W-1:0] dec_q, dec_d, dec_cur;
    logic [SAMPLE_W-1:0] sample, q_hold;
    logic [GAP_W-1:0] gap_q;
    logic accept, q_word, pair_done, frame_end, wr_en, drop, pop, full, empty, unused_rd;
    pair_t wr_pair, rd_pair;
    assign word_ready_o = clken_i;
    assign accept = word_valid_i & clken_i;
    assign sample = SAMPLE_W'(extract_sample(MAX_WORD_W'(word_i), WORD_W, SAMPLE_W, BYTE_SWAP));
    // sync_i acts on the current cycle, so a word arriving with it is already Q of channel 0.
    always_comb begin
        phase_cur = clken_i && sync_i ? Q_WAIT : phase_q;
        chan_cur = clken_i && sync_i ? '0 : chan_q;
        dec_cur = clken_i && sync_i ? '0 : dec_q;
        q_word = accept && phase_cur == Q_WAIT;
        pair_done = accept && phase_cur == I_WAIT;
        frame_end = pair_done && chan_cur == CHAN_W'(CHANNELS - 1);
        phase_d = accept ? (q_word ? I_WAIT : Q_WAIT) : phase_cur;
        chan_d = pair_done ? (frame_end ? '0 : chan_cur + CHAN_W'(1)) : chan_cur;
        dec_d = frame_end ? (dec_cur == DEC_W'(DECIM - 1) ? '0 : dec_cur + DEC_W'(1)) : dec_cur;
        // Full is the registered pre-pop flag: a same-cycle pop cannot make room.
        wr_en = pair_done && dec_cur == '0 && !full;
        drop = pair_done && dec_cur == '0 && full;
        pop = clken_i && !empty && gap_q == '0;
    end
    assign wr_pair = '{i: MAX_SAMPLE_W'(sample), q: MAX_SAMPLE_W'(q_hold), chan: MAX_CHAN_W'(chan_cur)};
    assign unused_rd = ^rd_pair;
    sync_fifo #(.WIDTH($bits(pair_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_ni (rst_ni),
        .wr_en  (wr_en),
        .wr_data(wr_pair),
        .rd_en  (pop),
        .rd_data(rd_pair),
        .full   (full),
        .empty  (empty)
    );
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= Q_WAIT;
            chan_q <= '0;
            dec_q <= '0;
            q_hold <= '0;
            gap_q <= '0;
        end else begin
            phase_q <= phase_d;
            chan_q <= chan_d;
            dec_q <= dec_d;
            if (q_word) q_hold <= sample;
            if (pop) gap_q <= GAP_W'(GAP - 1);
            else if (clken_i && gap_q != '0) gap_q <= gap_q - GAP_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            I_o <= '0;
            Q_o <= '0;
            chan_o <= '0;
            dvalid_o <= 1'b0;
            overrun_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            dvalid_o <= pop;
            if (pop) begin
                I_o <= SAMPLE_W'(rd_pair.i);
                Q_o <= SAMPLE_W'(rd_pair.q);
                chan_o <= CHAN_W'(rd_pair.chan);
            end
            if (drop) begin
                overrun_o <= 1'b1;
                drop_cnt_o <= err_clr_i ? 8'd1 : (drop_cnt_o == 8'hFF ? 8'hFF : drop_cnt_o + 8'd1);
            end else if (clken_i && err_clr_i) begin
                overrun_o <= 1'b0;
                drop_cnt_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_iq_word_unpacker.sv
// tb_iq_word_unpacker: directed scoreboard bench for a single-channel and a 3-channel/decimate-by-2 unpacker
module tb_iq_word_unpacker;
    logic clk = 1'b0, rst_n = 1'b0, clken = 1'b1;
    logic [15:0] w1 = '0, w3 = '0;
    logic v1 = 1'b0, s1 = 1'b0, e1 = 1'b0, v3 = 1'b0, s3 = 1'b0, e3 = 1'b0;
    logic d1_rdy, d1_dv, d1_ovr, d3_rdy, d3_dv, d3_ovr;
    logic [9:0] d1_i, d1_q, d3_i, d3_q;
    logic [0:0] d1_ch;
    logic [1:0] d3_ch;
    logic [7:0] d1_drop, d3_drop;
    int total = 0, bad = 0;
    typedef struct {logic [9:0] i; logic [9:0] q; logic [1:0] chan;} exp_t;
    exp_t q1[$], q3[$];
    bit sb1 = 1'b1, exact_gap = 1'b0, in_burst = 1'b0;
    int cyc = 0, last1 = -1000, last3 = -1000, n3 = 0;
    logic [15:0] qw, iw;

    always #5 clk = ~clk;

    iq_word_unpacker dut1 (
        .clk(clk), .rst_ni(rst_n), .clken_i(clken), .word_i(w1), .word_valid_i(v1),
        .word_ready_o(d1_rdy), .sync_i(s1), .err_clr_i(e1), .I_o(d1_i), .Q_o(d1_q),
        .chan_o(d1_ch), .dvalid_o(d1_dv), .overrun_o(d1_ovr), .drop_cnt_o(d1_drop));

    iq_word_unpacker #(.CHANNELS(3), .DECIM(2)) dut3 (
        .clk(clk), .rst_ni(rst_n), .clken_i(clken), .word_i(w3), .word_valid_i(v3),
        .word_ready_o(d3_rdy), .sync_i(s3), .err_clr_i(e3), .I_o(d3_i), .Q_o(d3_q),
        .chan_o(d3_ch), .dvalid_o(d3_dv), .overrun_o(d3_ovr), .drop_cnt_o(d3_drop));

    function automatic logic [9:0] samp(input logic [15:0] w);
        return {w[7:0], w[15:14]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [9:0] i, input logic [9:0] q);
        q1.push_back('{i: i, q: q, chan: 2'd0});
    endtask

    task automatic push3(input logic [9:0] i, input logic [9:0] q, input logic [1:0] c);
        q3.push_back('{i: i, q: q, chan: c});
    endtask

    task automatic send1(input logic [15:0] w, input bit s = 1'b0);
        w1 = w; v1 = 1'b1; s1 = s;
        @(posedge clk); #1;
        v1 = 1'b0; s1 = 1'b0;
    endtask

    task automatic send3(input logic [15:0] w, input bit s = 1'b0);
        w3 = w; v3 = 1'b1; s3 = s;
        @(posedge clk); #1;
        v3 = 1'b0; s3 = 1'b0;
    endtask

    task automatic drain;
        for (int k = 0; k < 300 && (q1.size() != 0 || q3.size() != 0); k++) @(negedge clk);
        repeat (8) @(negedge clk);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q3", q3.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            last1 = -1000;
            last3 = -1000;
        end else if (clken) begin
            cyc++;
            if (d1_dv) begin
                chk("gap1_min", 32'(cyc - last1 >= 4), 1);
                if (exact_gap && in_burst) chk("gap1_exact", cyc - last1, 4);
                in_burst = exact_gap;
                last1 = cyc;
                if (sb1) begin
                    chk("sb1_expected", 32'(q1.size() != 0), 1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        chk("sb1_I", d1_i, e.i);
                        chk("sb1_Q", d1_q, e.q);
                        chk("sb1_chan", d1_ch, e.chan);
                    end
                end
            end
            if (!exact_gap) in_burst = 1'b0;
            if (d3_dv) begin
                n3++;
                chk("gap3_min", 32'(cyc - last3 >= 4), 1);
                last3 = cyc;
                chk("sb3_expected", 32'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    chk("sb3_I", d3_i, e.i);
                    chk("sb3_Q", d3_q, e.q);
                    chk("sb3_chan", d3_ch, e.chan);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_I", d1_i, 0);
        chk("rst_Q", d1_q, 0);
        chk("rst_chan", d1_ch, 0);
        chk("rst_dv", d1_dv, 0);
        chk("rst_ovr", d1_ovr, 0);
        chk("rst_drop", d1_drop, 0);
        chk("rst_ready", d1_rdy, 1);
        chk("rst3_dv", d3_dv, 0);

        // basic extraction and latency
        send1(16'h0340);
        push1(10'h1FF, 10'h100);
        send1(16'hFF7F);
        @(negedge clk); chk("t1_lat_m1", d1_dv, 0);
        @(negedge clk); chk("t1_lat_m2", d1_dv, 1);
        chk("t1_Q", d1_q, 10'h100);
        chk("t1_I", d1_i, 10'h1FF);
        repeat (3) @(negedge clk);
        chk("t1_hold_I", d1_i, 10'h1FF);
        chk("t1_hold_dv", d1_dv, 0);
        drain;

        // back-to-back pairs: strobes every 4 cycles, pairs 8 and 10 find the FIFO full
        exact_gap = 1'b1;
        for (int k = 0; k < 12; k++) begin
            qw = 16'($urandom); iw = 16'($urandom);
            send1(qw);
            if (k != 8 && k != 10) push1(samp(iw), samp(qw));
            send1(iw);
        end
        drain;
        exact_gap = 1'b0;
        chk("t2_ovr", d1_ovr, 1);
        chk("t2_drop", d1_drop, 2);
        e1 = 1'b1; @(posedge clk); #1 e1 = 1'b0;
        @(negedge clk);
        chk("t2_clr_ovr", d1_ovr, 0);
        chk("t2_clr_drop", d1_drop, 0);

        // flood to saturation; the final dropped pair coincides with err_clr
        sb1 = 1'b0;
        for (int k = 0; k <= 600; k++) begin
            send1(16'h1234);
            if (k == 600) begin
                chk("sat_drop", d1_drop, 255);
                chk("sat_ovr", d1_ovr, 1);
                e1 = 1'b1;
            end
            send1(16'h5678);
            e1 = 1'b0;
        end
        @(negedge clk);
        chk("clr_drop_wins_cnt", d1_drop, 1);
        chk("clr_drop_wins_ovr", d1_ovr, 1);
        repeat (40) @(negedge clk);
        sb1 = 1'b1;

        // three channels, decimate by two: frames 0 and 2 reach the output
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 3; c++) begin
                qw = 16'($urandom); iw = 16'($urandom);
                send3(qw);
                if (f % 2 == 0) push3(samp(iw), samp(qw), 2'(c));
                send3(iw);
            end
        drain;
        chk("t3_strobes", n3, 6);
        chk("t3_ovr", d3_ovr, 0);
        chk("t3_ready", d3_rdy, 1);

        // sync with a word: that word becomes Q of channel 0, the stale Q vanishes
        send1(16'h1234);
        send1(16'h0100, 1'b1);
        push1(samp(16'hC0AB), samp(16'h0100));
        send1(16'hC0AB);
        send3(16'h1111);
        push3(samp(16'h2222), samp(16'h1111), 2'd0);
        send3(16'h2222);
        send3(16'h3333);
        send3(16'h4444, 1'b1);
        push3(samp(16'h5555), samp(16'h4444), 2'd0);
        send3(16'h5555);
        drain;
        chk("t4_Q", d1_q, 10'h000);
        chk("t4_I", d1_i, 10'h2AF);
        chk("t4_chan3", d3_ch, 0);

        // clock enable low freezes a pending pop and ignores input words
        push1(samp(16'h8001), samp(16'h4002));
        send1(16'h4002);
        send1(16'h8001);
        clken = 1'b0;
        w1 = 16'hAAAA; v1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_dv_frozen", d1_dv, 0);
        end
        chk("t5_ready", d1_rdy, 0);
        v1 = 1'b0;
        @(posedge clk); #1 clken = 1'b1;
        @(negedge clk); chk("t5_resume_m0", d1_dv, 0);
        @(negedge clk); chk("t5_resume_m1", d1_dv, 1);
        drain;
        push1(samp(16'hFFC0), samp(16'h0F03));
        send1(16'h0F03);
        send1(16'hFFC0);
        drain;

        // reset with three pairs still buffered
        for (int k = 0; k < 5; k++) begin
            qw = 16'($urandom); iw = 16'($urandom);
            send1(qw);
            if (k < 2) push1(samp(iw), samp(qw));
            send1(iw);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_async_I", d1_i, 0);
        chk("t6_async_Q", d1_q, 0);
        chk("t6_async_dv", d1_dv, 0);
        chk("t6_async_ovr", d1_ovr, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_leftover", q1.size(), 0);
        chk("t6_quiet", d1_dv, 0);
        push1(samp(16'h00FF), samp(16'hFF00));
        send1(16'hFF00);
        send1(16'h00FF);
        drain;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
